// File: rtl/blockade_outport.sv
// blockade_outport: CPU OUT-port responder for the Blockade sound board.
// Captures writes to ports 1 (tone period), 2 (control) and 4 (envelope
// trigger) and produces an 8-bit unsigned audio sample.
// Optional build macro: BLOCKADE_OUTPORT_NOISE_EN adds the LFSR noise path;
// without it the noise bit is tied low and ctrl[1] has no audible effect.
//
// Envelope FSM states:
//   state | meaning
//   IDLE  | no envelope running, level holds its last value (0 after decay)
//   DECAY | level counts down from 255 by one every DECAY_DIV ce pulses

module blockade_outport #(
    parameter int          TONE_PRESCALE = 16,
    parameter int          DECAY_DIV     = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       outp,
    input  logic [2:0] port_addr,
    input  logic [7:0] port_data,
    output logic [7:0] audio,
    output logic       env_active,
    output logic       coin_lockout
);

    localparam int TP_W = (TONE_PRESCALE > 1) ? $clog2(TONE_PRESCALE) : 1;
    localparam int DP_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [TP_W-1:0] TP_MAX = TP_W'(TONE_PRESCALE - 1);
    localparam logic [DP_W-1:0] DP_MAX = DP_W'(DECAY_DIV - 1);

    typedef enum logic {IDLE, DECAY} env_state_t;

    logic            outp_last;
    logic            wr_stb;
    logic            wr_tone;
    logic            wr_ctrl;
    logic            env_trig;
    logic [2:0]      ctrl;
    logic [7:0]      tone_period;
    logic [7:0]      tone_cnt;
    logic [TP_W-1:0] tone_pre;
    logic            tone_wrap;
    logic            tone_bit;
    logic            noise_bit;
    env_state_t      state, state_next;
    logic [7:0]      level, level_next;
    logic [DP_W-1:0] decay_pre, decay_pre_next;
    logic [7:0]      tone_amp;
    logic [7:0]      noise_amp;

    // The strobe is the rising edge of the OUT level, so one capture per cycle.
    assign wr_stb    = outp & ~outp_last;
    assign wr_tone   = wr_stb && (port_addr == 3'd1);
    assign wr_ctrl   = wr_stb && (port_addr == 3'd2);
    assign env_trig  = wr_stb && (port_addr == 3'd4);
    assign tone_wrap = ce && (tone_pre == TP_MAX);

    // Strobe history, control register and tone generator.
    always_ff @(posedge clk) begin
        if (reset) begin
            outp_last   <= 1'b0;
            ctrl        <= 3'd0;
            tone_period <= 8'd0;
            tone_cnt    <= 8'd0;
            tone_pre    <= '0;
            tone_bit    <= 1'b0;
        end else begin
            outp_last <= outp;
            if (wr_ctrl)
                ctrl <= port_data[2:0];
            if (wr_tone) begin
                // A period write overrides any terminal count in the same cycle.
                tone_period <= port_data;
                tone_cnt    <= port_data;
                tone_pre    <= '0;
            end else if (ce) begin
                tone_pre <= tone_wrap ? '0 : tone_pre + 1'b1;
                if (tone_wrap) begin
                    if (tone_period == 8'd0) begin
                        tone_bit <= 1'b0;
                    end else if (tone_cnt == 8'd0) begin
                        tone_cnt <= tone_period;
                        tone_bit <= ~tone_bit;
                    end else begin
                        tone_cnt <= tone_cnt - 8'd1;
                    end
                end
            end
        end
    end

`ifdef BLOCKADE_OUTPORT_NOISE_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) stepped on every tone prescaler wrap.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else if (tone_wrap)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign noise_bit = lfsr[15];
`else
    assign noise_bit = 1'b0;
`endif

    // Envelope state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            level     <= 8'd0;
            decay_pre <= '0;
        end else begin
            state     <= state_next;
            level     <= level_next;
            decay_pre <= decay_pre_next;
        end
    end

    // Envelope next-state: a trigger always restarts at full level.
    always_comb begin
        state_next     = state;
        level_next     = level;
        decay_pre_next = decay_pre;
        if (env_trig) begin
            state_next     = DECAY;
            level_next     = 8'd255;
            decay_pre_next = '0;
        end else begin
            case (state)
                IDLE: ;
                DECAY: begin
                    if (ce) begin
                        if (decay_pre == DP_MAX) begin
                            decay_pre_next = '0;
                            level_next     = level - 8'd1;
                            if (level == 8'd1)
                                state_next = IDLE;
                        end else begin
                            decay_pre_next = decay_pre + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign tone_amp  = (ctrl[0] & tone_bit) ? 8'h7F : 8'h00;
    assign noise_amp = (ctrl[1] & noise_bit) ? {1'b0, level[7:1]} : 8'h00;

    // Registered mixer; the sum peaks at 254 so 8 bits cannot overflow.
    always_ff @(posedge clk) begin
        if (reset)
            audio <= 8'd0;
        else
            audio <= tone_amp + noise_amp;
    end

    assign env_active   = (state == DECAY);
    assign coin_lockout = ctrl[2];

endmodule
